// File: rtl/dlfloat_pkg.sv
// Shared DLfloat16 definitions.
//   DLF_W / DLF_ZERO / DLF_ONE / DLF_EXP_BIAS : the number format
//     (1 sign bit, 6 exponent bits with bias 31, 9 mantissa bits).
//   seq_state_t : states of the MAC job sequencer.
package dlfloat_pkg;

    localparam int             DLF_W        = 16;
    localparam logic [DLF_W-1:0] DLF_ZERO   = 16'h0000;
    localparam logic [DLF_W-1:0] DLF_ONE    = 16'h3E00;  // exp = bias, mantissa = 0
    localparam int             DLF_EXP_BIAS = 31;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        DRAIN,
        DONE
    } seq_state_t;

endpackage

// File: rtl/dlfloat_mac_sequencer.sv
// Sequences one dot-product job on the DLfloat16 MAC datapath.
//
// A job is started with start/cfg_len. The accumulator is cleared (mac_clr)
// before the first pair, then cfg_len operand pairs are accepted over the
// in_valid/in_ready stream and forwarded one per cycle to the MAC with a
// mac_en strobe. After the last pair the sequencer waits for the MAC
// pipeline to settle, captures mac_acc and holds it on out_data/out_valid
// until the consumer takes it with out_ready.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start, cfg_len      : job start and length (sampled in IDLE only)
//   busy                : high whenever a job is in progress
//   in_valid/in_ready   : operand stream handshake, in_a/in_b operands
//   mac_a, mac_b        : registered operands to the MAC
//   mac_en, mac_clr     : accumulate / clear strobes to the MAC
//   mac_acc             : accumulator value from the MAC
//   out_valid/out_ready : result handshake, out_data result
module dlfloat_mac_sequencer
    import dlfloat_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int CNT_W   = 8,
    parameter int MAC_LAT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  cfg_len,
    output logic              busy,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic [DATA_W-1:0] mac_a,
    output logic [DATA_W-1:0] mac_b,
    output logic              mac_en,
    output logic              mac_clr,
    input  logic [DATA_W-1:0] mac_acc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    localparam int DRAIN_W = $clog2(MAC_LAT + 1);

    seq_state_t         state_q, state_d;
    logic [CNT_W-1:0]   len_q;
    logic [CNT_W-1:0]   issue_cnt;
    logic [DRAIN_W-1:0] drain_cnt;
    logic               last_pair;

    // The pair accepted when issue_cnt == len_q-1 is the final one of the job.
    assign last_pair = (issue_cnt == len_q - CNT_W'(1));

    // Next-state and combinational outputs.
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave it unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        busy     = 1'b1;
        in_ready = 1'b0;
        mac_clr  = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = (cfg_len == '0) ? DONE : CLEAR;
                end
            end
            CLEAR: begin
                mac_clr = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                in_ready = 1'b1;
                if (in_valid && last_pair) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_cnt == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register, counters and registered outputs.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            len_q     <= '0;
            issue_cnt <= '0;
            drain_cnt <= '0;
            mac_a     <= '0;
            mac_b     <= '0;
            mac_en    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            state_q <= state_d;
            mac_en  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        len_q     <= cfg_len;
                        issue_cnt <= '0;
                        if (cfg_len == '0) begin
                            out_data  <= DATA_W'(DLF_ZERO);
                            out_valid <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (in_valid) begin
                        mac_a     <= in_a;
                        mac_b     <= in_b;
                        mac_en    <= 1'b1;
                        issue_cnt <= issue_cnt + CNT_W'(1);
                        if (last_pair) begin
                            drain_cnt <= DRAIN_W'(MAC_LAT);
                        end
                    end
                end
                DRAIN: begin
                    // The counter covers the MAC_LAT cycles after the final
                    // mac_en cycle; at zero the last contribution has been on
                    // mac_acc for a full cycle and is safe to capture.
                    if (drain_cnt == '0) begin
                        out_data  <= mac_acc;
                        out_valid <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - DRAIN_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
